// File: rtl/gcd_fsm.sv
// Euclid-by-subtraction GCD engine driving an external magnitude comparator.
// Optional step counter output enabled by defining GCD_STEPS_EN.
module gcd_fsm #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] cmp_a,
  output logic [N-1:0] cmp_b,
  input  logic         a_lt_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         dbg_state
`ifdef GCD_STEPS_EN
  ,
  output logic [N-1:0] steps
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] result_q, result_d;
  logic         done_q, done_d;
  logic         finish;

`ifdef GCD_STEPS_EN
  logic [N-1:0] steps_q, steps_d;
`endif

  // Equality and zero detection stay local; only ordering comes from cmp.
  assign finish = (a_q == b_q) || (a_q == '0) || (b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef GCD_STEPS_EN
      steps_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef GCD_STEPS_EN
      steps_q  <= steps_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef GCD_STEPS_EN
    steps_d  = steps_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_RUN;
`ifdef GCD_STEPS_EN
          steps_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (finish) begin
          // OR of the operands covers gcd(x,x), gcd(0,x) and gcd(0,0).
          result_d = a_q | b_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          if (a_lt_b) begin
            b_d = b_q - a_q;
          end else begin
            a_d = a_q - b_q;
          end
`ifdef GCD_STEPS_EN
          steps_d = steps_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmp_a     = a_q;
  assign cmp_b     = b_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;
`ifdef GCD_STEPS_EN
  assign steps     = steps_q;
`endif

endmodule

// File: tb/tb_gcd_fsm.sv
// Scoreboard bench for gcd_fsm; the comparator is modelled inline.
// Step counts are checked only when GCD_STEPS_EN is defined.
module tb_gcd_fsm;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] cmp_a;
  logic [N-1:0] cmp_b;
  logic         a_lt_b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         dbg_state;
`ifdef GCD_STEPS_EN
  logic [N-1:0] steps;
`endif

  int unsigned  cyc;
  int           checks;
  int           errors;

  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];

  gcd_fsm #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .a_lt_b    (a_lt_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
`ifdef GCD_STEPS_EN
    ,
    .steps     (steps)
`endif
  );

  // Comparator model: purely combinational magnitude compare.
  assign a_lt_b = (cmp_a < cmp_b);

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: call mid-cycle; returns 1 time unit after the start edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] res, input int lat);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(res);
    exp_cyc_q.push_back(int'(cyc) + lat);
    check("busy_after_start", int'(busy), 1);
    check("cmp_a_loaded", int'(cmp_a), int'(a));
    check("cmp_b_loaded", int'(cmp_b), int'(b));
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [N-1:0] e;
    int           ec;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", int'(result), int'(e));
          check("done_latency_cycle", int'(cyc), ec);
          check("busy_low_at_done", int'(busy), 0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_result", int'(result), 0);
    check("reset_cmp_a", int'(cmp_a), 0);
    check("reset_state", int'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: (12,18) -> B=6, A=6, result 6, latency 3
    issue(8'd12, 8'd18, 8'd6, 3);
    @(posedge clk); #1;
    check("basic_b_6", int'(cmp_b), 6);
    @(posedge clk); #1;
    check("basic_a_6", int'(cmp_a), 6);
    check("basic_busy_mid", int'(busy), 1);
    wait_done(20);
`ifdef GCD_STEPS_EN
    check("basic_steps", int'(steps), 2);
`endif
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);

    // Zero operands
    issue(8'd0, 8'd35, 8'd35, 1);
    wait_done(20);
`ifdef GCD_STEPS_EN
    check("zero35_steps", int'(steps), 0);
`endif
    @(negedge clk);
    issue(8'd0, 8'd0, 8'd0, 1);
    wait_done(20);
`ifdef GCD_STEPS_EN
    check("zero0_steps", int'(steps), 0);
`endif
    @(negedge clk);

    // Worst case (1,255) with an ignored start (9,3) during RUN
    issue(8'd1, 8'd255, 8'd1, 255);
    repeat (20) @(negedge clk);
    start = 1'b1;
    op_a  = 8'd9;
    op_b  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("ignored_start_busy", int'(busy), 1);
    check("ignored_start_a", int'(cmp_a), 1);
    wait_done(400);
`ifdef GCD_STEPS_EN
    check("worst_steps", int'(steps), 254);
`endif
    @(negedge clk);
    check("ignored_start_idle", int'(busy), 0);

    // Back-to-back: (48,36) then (7,5) in the done cycle
    issue(8'd48, 8'd36, 8'd12, 4);
    wait_done(20);
    issue(8'd7, 8'd5, 8'd1, 5);
    wait_done(20);
`ifdef GCD_STEPS_EN
    check("b2b_steps", int'(steps), 4);
`endif
    @(negedge clk);

    // Reset mid-operation on (1,200)
    issue(8'd1, 8'd200, 8'd1, 200);
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_cmp_a", int'(cmp_a), 0);
    check("midrst_cmp_b", int'(cmp_b), 0);
`ifdef GCD_STEPS_EN
    check("midrst_steps", int'(steps), 0);
`endif
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    check("midrst_no_done_busy", int'(busy), 0);
    issue(8'd21, 8'd14, 8'd7, 3);
    wait_done(20);
`ifdef GCD_STEPS_EN
    check("after_rst_steps", int'(steps), 2);
`endif
    repeat (5) @(negedge clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_fsm.md
# gcd_fsm

- Sequential greatest-common-divisor engine for the calculator datapath, using Euclid's algorithm by repeated subtraction.
- Sits directly upstream of the `cmp` magnitude comparator:
  - drives the comparator's operand inputs from its working registers;
  - consumes the comparator's `a_lt_b` result to choose each subtraction step.
- Accepts two N-bit operands on a start pulse and returns the GCD with a one-cycle done pulse.

## Interface
- `N`, default 8: operand, result and working-register width.
- `clk` input, 1: system clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `start` input, 1: request; sampled only in IDLE.
- `op_a` input, N: first operand, captured on an accepted start.
- `op_b` input, N: second operand, captured on an accepted start.
- `cmp_a` output, N: working register A, wired to the comparator `a` input.
- `cmp_b` output, N: working register B, wired to the comparator `b` input.
- `a_lt_b` input, 1: comparator result, treated as combinational (A < B) within the same cycle.
- `busy` output, 1: high while in RUN.
- `done` output, 1: one-cycle pulse when `result` is updated.
- `result` output, N: GCD of the last completed operation; holds its value until the next completion.
- `steps` output, N: present only with `GCD_STEPS_EN` (see Configuration).

## Operation
- **States:** IDLE, RUN. Encoding is free.
- **Reset** (`rst_n` = 0, asynchronous): state = IDLE; A = B = 0; `busy` = 0; `done` = 0; `result` = 0; `steps` = 0.
- **IDLE:**
  - `start` = 1 at an edge: A ← `op_a`, B ← `op_b`, state → RUN.
  - `start` = 0: hold state.
- **RUN, terminating edge** (A == B, or A == 0, or B == 0):
  - `result` ← A | B, which yields gcd(x,x) = x, gcd(0,x) = x and gcd(0,0) = 0;
  - `done` ← 1; state → IDLE.
- **RUN, otherwise:**
  - `a_lt_b` = 1: B ← B − A.
  - `a_lt_b` = 0: A ← A − B.
- **Arithmetic:**
  - Subtractions are N-bit unsigned and never underflow, because the larger operand minus the smaller is always non-negative.
  - No carry bit is kept.
- **Equality** is detected internally; only the ordering comes from the comparator.
- **`start` while RUN:** ignored; operands are not re-captured.
- **`start` in the cycle `done` is high:** the FSM is already in IDLE, so the start is accepted and the next operation begins without a gap.
- **Reset mid-operation:** the operation is discarded and no `done` is produced.
- **Outputs are registered:**
  - `busy` = (state == RUN);
  - `done` is high for exactly one cycle per completed operation.

## Timing
- **Start edge** = edge at which `start` is sampled in IDLE.
- **Subtraction count:** k = number of subtraction edges for the operand pair.
- **Latency:** `done` and a valid `result` appear after edge k+1 counted from the start edge.
  - Equal or zero operands complete on the first RUN edge (latency 1).
- **Worst case:** for N = 8, (1,255) gives k = 254, so latency is 255 cycles.
- **Busy:** `busy` rises after the start edge and falls on the same edge that raises `done`.
- **Comparator path:** `cmp_a`/`cmp_b` change only on clock edges; `a_lt_b` must settle within one cycle.

## Configuration
- **`GCD_STEPS_EN` defined:**
  - adds output `steps[N-1:0]`, reset 0;
  - cleared to 0 on an accepted start;
  - incremented on every subtraction edge;
  - equals k when `done` pulses and holds until the next accepted start.
  - The maximum value 2^N − 2 fits in N bits without saturation logic.
- **`GCD_STEPS_EN` undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Basic GCD:** reset, then `start` with `op_a` = 12, `op_b` = 18.
  - Expect B = 6, then A = 6.
  - `done` pulses after edge 3 with `result` = 6; `busy` is high for 3 cycles; `steps` = 2.
- **Zero operands:**
  - (0,35) → `result` = 35 at latency 1;
  - (0,0) → `result` = 0 at latency 1;
  - `steps` = 0 in both cases.
- **Worst case:** (1,255) with N = 8 → `result` = 1, `done` at latency 255, `steps` = 254.
  - A `start` pulse with (9,3) during RUN is ignored; `result` is still 1.
- **Back-to-back:** after (48,36) completes with `result` = 12, assert `start` with (7,5) in the `done` cycle.
  - Expect it to be accepted immediately; the second `done` gives `result` = 1.
- **Reset mid-operation:** assert `rst_n` low midway through (1,200).
  - All outputs go to 0 immediately (asynchronous reset).
  - No `done` appears afterwards.
  - A subsequent (21,14) gives `result` = 7.
